action_scheduler: RTL and testbench

//  Selects one miniCar Action from three requesters: IR remote, autoTracking and avoidObject.

---
 rtl/mini_car_pkg.sv | 24 ++
 rtl/action_scheduler_if.sv | 26 ++
 rtl/sched_tick_cnt.sv | 27 ++
 rtl/action_scheduler.sv | 104 ++++++++++
 tb/tb_action_scheduler.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/mini_car_pkg.sv
// rtl/mini_car_pkg.sv - miniCar action codes, scheduler state codes and sanitiser
package mini_car_pkg;

  localparam int ACT_W = 4;

  localparam logic [ACT_W-1:0] ACT_STOP  = 4'd0;
  localparam logic [ACT_W-1:0] ACT_FWD   = 4'd1;
  localparam logic [ACT_W-1:0] ACT_BACK  = 4'd2;
  localparam logic [ACT_W-1:0] ACT_LEFT  = 4'd3;
  localparam logic [ACT_W-1:0] ACT_RIGHT = 4'd4;
  localparam logic [ACT_W-1:0] ACT_BRAKE = 4'd5;

  typedef enum logic [1:0] {
    S_STOP  = 2'b00,
    S_RUN   = 2'b01,
    S_BRAKE = 2'b10
  } sched_state_e;

  // Requesters may only ask for motion; BRAKE and undefined codes become STOP.
  function automatic logic [ACT_W-1:0] sanitise(input logic [ACT_W-1:0] a);
    return (a >= ACT_BRAKE) ? ACT_STOP : a;
  endfunction

endpackage

// File: rtl/action_scheduler_if.sv
// rtl/action_scheduler_if.sv - requester inputs and motor-action outputs of the scheduler
interface action_scheduler_if;
  import mini_car_pkg::*;

  logic             tick_1ms;
  logic [1:0]       miniCarMode;
  logic [ACT_W-1:0] action_ir;
  logic [ACT_W-1:0] action_track;
  logic [ACT_W-1:0] action_avoid;
  logic             obstacle_near;
  logic [ACT_W-1:0] action_out;
  logic             brake_active;
  logic             override_flag;
  logic [1:0]       sched_state;

  modport master (
    output tick_1ms, miniCarMode, action_ir, action_track, action_avoid, obstacle_near,
    input  action_out, brake_active, override_flag, sched_state
  );

  modport slave (
    input  tick_1ms, miniCarMode, action_ir, action_track, action_avoid, obstacle_near,
    output action_out, brake_active, override_flag, sched_state
  );

endinterface

// File: rtl/sched_tick_cnt.sv
// rtl/sched_tick_cnt.sv - tick-enabled saturating counter with priority clear
module sched_tick_cnt #(
  parameter int W = 8
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         tick_i,
  input  logic         clr_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (tick_i && (cnt_q < limit_i)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/action_scheduler.sv
// rtl/action_scheduler.sv - motor-safe action arbiter: hold, active brake, coast dead-time
module action_scheduler
  import mini_car_pkg::*;
#(
  parameter int HOLD_MS  = 100,
  parameter int BRAKE_MS = 20,
  parameter int DEAD_MS  = 50,
  parameter int CNT_W    = 8
) (
  input  logic         clk_in,
  input  logic         rst_n,
  action_scheduler_if.slave bus
);

  sched_state_e     state_q, state_d;
  logic [ACT_W-1:0] action_q, action_d;
  logic [ACT_W-1:0] req_raw, req_san, req;
  logic [1:0]       mode_q;
  logic             brake_q, override_q, override_d;
  logic             mode_chg, clr;
  logic [CNT_W-1:0] cnt, limit;

  always_comb begin
    case (bus.miniCarMode)
      2'd0:    req_raw = bus.action_ir;
      2'd1:    req_raw = bus.action_track;
      2'd2:    req_raw = bus.action_avoid;
      default: req_raw = ACT_STOP;
    endcase
    req_san    = sanitise(req_raw);
    // Avoid mode owns obstacle handling itself; elsewhere forward is inhibited.
    override_d = bus.obstacle_near && (bus.miniCarMode != 2'd2) && (req_san == ACT_FWD);
    req        = override_d ? ACT_STOP : req_san;
    mode_chg   = (bus.miniCarMode != mode_q);
  end

  always_comb begin
    state_d  = state_q;
    action_d = action_q;
    limit    = CNT_W'(BRAKE_MS);
    case (state_q)
      S_STOP: begin
        limit    = CNT_W'(DEAD_MS);
        action_d = ACT_STOP;
        if ((req != ACT_STOP) && (cnt >= CNT_W'(DEAD_MS))) begin
          state_d  = S_RUN;
          action_d = req;
        end
      end
      S_RUN: begin
        limit = CNT_W'(HOLD_MS);
        // STOP and mode changes bypass the hold; other changes wait it out.
        if ((req == ACT_STOP) || mode_chg ||
            ((req != action_q) && (cnt >= CNT_W'(HOLD_MS)))) begin
          state_d  = S_BRAKE;
          action_d = ACT_BRAKE;
        end
      end
      S_BRAKE: begin
        action_d = ACT_BRAKE;
        if (cnt >= CNT_W'(BRAKE_MS)) begin
          state_d  = S_STOP;
          action_d = ACT_STOP;
        end
      end
      default: begin
        state_d  = S_BRAKE;
        action_d = ACT_BRAKE;
      end
    endcase
    clr = (state_d != state_q);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_STOP;
      action_q   <= ACT_STOP;
      brake_q    <= 1'b0;
      override_q <= 1'b0;
      mode_q     <= 2'd0;
    end else begin
      state_q    <= state_d;
      action_q   <= action_d;
      brake_q    <= (state_d == S_BRAKE);
      override_q <= override_d;
      mode_q     <= bus.miniCarMode;
    end
  end

  sched_tick_cnt #(.W(CNT_W)) u_cnt (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .tick_i  (bus.tick_1ms),
    .clr_i   (clr),
    .limit_i (limit),
    .cnt_o   (cnt)
  );

  assign bus.action_out    = action_q;
  assign bus.brake_active  = brake_q;
  assign bus.override_flag = override_q;
  assign bus.sched_state   = state_q;

endmodule

// File: tb/tb_action_scheduler.sv
// tb/tb_action_scheduler.sv - directed self-checking bench for action_scheduler
module tb_action_scheduler;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  action_scheduler_if ifc ();

  action_scheduler #(
    .HOLD_MS  (4),
    .BRAKE_MS (2),
    .DEAD_MS  (3),
    .CNT_W    (8)
  ) dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns just after the edge that sampled the n-th tick.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      ifc.tick_1ms = 1'b1;
      cyc(1);
      ifc.tick_1ms = 1'b0;
      if (i < n - 1) cyc(9);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    ifc.tick_1ms      = 1'b0;
    ifc.miniCarMode   = 2'd0;
    ifc.action_ir     = 4'd1;
    ifc.action_track  = 4'd0;
    ifc.action_avoid  = 4'd0;
    ifc.obstacle_near = 1'b0;
    #12 rst_n = 1'b1;
    cyc(1);

    chk("reset_action", ifc.action_out, 4'd0);
    chk("reset_state", {2'b00, ifc.sched_state}, 4'd0);
    chk("reset_brake", {3'b000, ifc.brake_active}, 4'd0);
    chk("reset_override", {3'b000, ifc.override_flag}, 4'd0);

    // 1: dead-time after reset, then FWD
    ticks(3);
    chk("t1_wait_dead", ifc.action_out, 4'd0);
    cyc(1);
    chk("t1_run_fwd", ifc.action_out, 4'd1);
    chk("t1_state_run", {2'b00, ifc.sched_state}, 4'd1);

    // 2: reversal honours hold, brake and dead-time
    cyc(9);
    ticks(1);
    ifc.action_ir = 4'd2;
    ticks(3);
    chk("t2_hold", ifc.action_out, 4'd1);
    cyc(1);
    chk("t2_brake", ifc.action_out, 4'd5);
    chk("t2_brake_active", {3'b000, ifc.brake_active}, 4'd1);
    chk("t2_state_brake", {2'b00, ifc.sched_state}, 4'd2);
    ticks(2);
    chk("t2_brake_held", ifc.action_out, 4'd5);
    cyc(1);
    chk("t2_stop", ifc.action_out, 4'd0);
    chk("t2_brake_off", {3'b000, ifc.brake_active}, 4'd0);
    ticks(3);
    chk("t2_dead", ifc.action_out, 4'd0);
    cyc(1);
    chk("t2_back", ifc.action_out, 4'd2);

    // 3: STOP request brakes immediately
    ticks(1);
    ifc.action_ir = 4'd0;
    cyc(1);
    chk("t3_brake", ifc.action_out, 4'd5);
    chk("t3_brake_active", {3'b000, ifc.brake_active}, 4'd1);
    ticks(2);
    cyc(1);
    chk("t3_stop", ifc.action_out, 4'd0);
    chk("t3_state_stop", {2'b00, ifc.sched_state}, 4'd0);

    // 4: obstacle inhibits FWD outside avoid mode
    ifc.action_ir = 4'd1;
    ticks(3);
    cyc(1);
    chk("t4_run_fwd", ifc.action_out, 4'd1);
    ifc.obstacle_near = 1'b1;
    cyc(1);
    chk("t4_override", {3'b000, ifc.override_flag}, 4'd1);
    chk("t4_brake", ifc.action_out, 4'd5);
    ticks(2);
    cyc(1);
    chk("t4_stop", ifc.action_out, 4'd0);
    ifc.miniCarMode  = 2'd2;
    ifc.action_avoid = 4'd1;
    cyc(1);
    chk("t4_avoid_no_override", {3'b000, ifc.override_flag}, 4'd0);
    ticks(3);
    cyc(1);
    chk("t4_avoid_fwd", ifc.action_out, 4'd1);
    ticks(1);
    cyc(1);
    chk("t4_avoid_stays_fwd", ifc.action_out, 4'd1);

    // 5: mode change brakes even with the same code
    ifc.obstacle_near = 1'b0;
    ifc.miniCarMode   = 2'd1;
    ifc.action_track  = 4'd3;
    cyc(1);
    chk("t5_modechg_brake", ifc.action_out, 4'd5);
    ticks(2);
    cyc(1);
    ticks(3);
    cyc(1);
    chk("t5_run_left", ifc.action_out, 4'd3);
    ifc.action_ir   = 4'd3;
    ifc.miniCarMode = 2'd0;
    cyc(1);
    chk("t5_same_code_brake", ifc.action_out, 4'd5);
    ticks(2);
    cyc(1);
    chk("t5_stop", ifc.action_out, 4'd0);
    ticks(3);
    chk("t5_dead", ifc.action_out, 4'd0);
    cyc(1);
    chk("t5_left", ifc.action_out, 4'd3);

    // 6: sanitising and asynchronous reset mid-brake
    ifc.action_ir = 4'd9;
    cyc(1);
    chk("t6_code9_brake", ifc.action_out, 4'd5);
    ticks(2);
    cyc(1);
    ifc.action_ir = 4'd5;
    ticks(3);
    cyc(1);
    chk("t6_code5_stop", ifc.action_out, 4'd0);
    chk("t6_code5_state", {2'b00, ifc.sched_state}, 4'd0);
    ifc.action_ir = 4'd4;
    cyc(1);
    chk("t6_run_right", ifc.action_out, 4'd4);
    ifc.action_ir = 4'd0;
    cyc(1);
    chk("t6_brake_pre_rst", {3'b000, ifc.brake_active}, 4'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_action", ifc.action_out, 4'd0);
    chk("t6_async_brake", {3'b000, ifc.brake_active}, 4'd0);
    chk("t6_async_state", {2'b00, ifc.sched_state}, 4'd0);
    #3 rst_n = 1'b1;
    cyc(1);

    // forced-stop mode ignores requests; dead-time restarts after reset
    ifc.miniCarMode = 2'd3;
    ifc.action_ir   = 4'd1;
    ticks(3);
    cyc(1);
    chk("mode3_stop", ifc.action_out, 4'd0);
    ifc.miniCarMode = 2'd0;
    cyc(1);
    chk("mode0_fwd", ifc.action_out, 4'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
